// File: rtl/otter_pkg.sv
// Shared load/store definitions for the memory stage:
// funct3 encodings, FSM states and size/lane helper functions.
package otter_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_BUSY,
        LSU_DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } lsu_size_t;

    // Any encoding that is not a byte or halfword access is a word
    function automatic lsu_size_t size_of(input logic [2:0] f3);
        lsu_size_t sz;
        case (f3)
            F3_LB, F3_LBU: sz = SZ_B;
            F3_LH, F3_LHU: sz = SZ_H;
            default:       sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] be_of(input lsu_size_t sz,
                                         input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_of(input lsu_size_t sz,
                                             input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_B:    w = {4{d[7:0]}};
            SZ_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus bundle between the LSU (master) and memory (slave).
interface mem_stage_lsu_if;

    logic        DMemReq;
    logic        DMemWe;
    logic [31:0] DMemAddr;
    logic [3:0]  DMemBe;
    logic [31:0] DMemWData;
    logic [31:0] DMemRData;
    logic        DMemAck;

    modport master (
        output DMemReq, DMemWe, DMemAddr, DMemBe, DMemWData,
        input  DMemRData, DMemAck
    );

    modport slave (
        input  DMemReq, DMemWe, DMemAddr, DMemBe, DMemWData,
        output DMemRData, DMemAck
    );

endinterface

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension of the returned bus word.
module lsu_load_align
    import otter_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sext;

    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
        sext   = ~funct3[2];
        case (size_of(funct3))
            SZ_B:    data = {{24{sext & byte_v[7]}}, byte_v};
            SZ_H:    data = {{16{sext & half_v[15]}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: IDLE/BUSY/DONE bus sequencer with stall.
// Optional `LSU_MISALIGN_TRAP_EN adds MisalignM and suppresses misaligned access.
module mem_stage_lsu
    import otter_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [3:0]  DMemBe,
    output logic [31:0] DMemWData,
    input  logic [31:0] DMemRData,
    input  logic        DMemAck,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        MisalignM,
`endif
    output logic [31:0] ReadDataM,
    output logic        StallM
);

    lsu_state_t  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] load_data;
    lsu_size_t   sz;
    logic        access;
    logic        mis;
    logic        go;
    logic        stall;

    assign sz     = size_of(Funct3M);
    assign access = MemReadM | MemWriteM;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = ((sz == SZ_H) && ALUResultM[0]) ||
                 ((sz == SZ_W) && (ALUResultM[1:0] != 2'b00));
    assign MisalignM = access & mis;
`else
    assign mis = 1'b0;
`endif

    assign go = access & ~mis;

    lsu_load_align u_align (
        .funct3 (f3_q),
        .off    (off_q),
        .rdata  (DMemRData),
        .data   (load_data)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        unique case (state_q)
            LSU_IDLE: begin
                if (go) begin
                    stall   = 1'b1;
                    state_d = LSU_BUSY;
                    we_d    = MemWriteM;
                    addr_d  = {ALUResultM[31:2], 2'b00};
                    be_d    = be_of(sz, ALUResultM[1:0]);
                    wdata_d = wdata_of(sz, WriteDataM);
                    f3_d    = Funct3M;
                    off_d   = ALUResultM[1:0];
                end
            end
            LSU_BUSY: begin
                stall = 1'b1;
                if (DMemAck) begin
                    state_d = LSU_DONE;
                    if (!we_q) rdata_d = load_data;
                end
            end
            // Always leave DONE so the frozen instruction is not re-issued
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= LSU_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
        end
    end

    assign DMemReq   = (state_q == LSU_BUSY);
    assign DMemWe    = we_q;
    assign DMemAddr  = addr_q;
    assign DMemBe    = be_q;
    assign DMemWData = wdata_q;
    assign ReadDataM = rdata_q;
    assign StallM    = stall & RST_N;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed accesses, queued expectations.
module tb_mem_stage_lsu;
    import otter_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        MisalignM;
`endif

    mem_stage_lsu_if bus ();

    mem_stage_lsu dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .DMemReq    (bus.DMemReq),
        .DMemWe     (bus.DMemWe),
        .DMemAddr   (bus.DMemAddr),
        .DMemBe     (bus.DMemBe),
        .DMemWData  (bus.DMemWData),
        .DMemRData  (bus.DMemRData),
        .DMemAck    (bus.DMemAck),
`ifdef LSU_MISALIGN_TRAP_EN
        .MisalignM  (MisalignM),
`endif
        .ReadDataM  (ReadDataM),
        .StallM     (StallM)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          stalls;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    int          nreq = 0;
    int          exp_nreq = 0;
    bit          active = 0;
    bit          done_nxt = 0;
    bit          prev_req = 0;
    int          cnt = 0;
    logic [31:0] last_rd = '0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Monitor: pops an expectation on each new request, checks the DONE cycle
    always @(negedge CLK) begin
        if (!RST_N) begin
            active   = 0;
            done_nxt = 0;
            prev_req = 0;
            cnt      = 0;
        end else begin
            if (done_nxt) begin
                done_nxt = 0;
                active   = 0;
                chk("done_rdata", ReadDataM, cur.rdata);
                chk("done_stall", {31'b0, StallM}, 32'd0);
                chk("done_req", {31'b0, bus.DMemReq}, 32'd0);
                chk("stall_cycles", cnt, cur.stalls);
                cnt = 0;
            end else if (StallM) begin
                cnt++;
            end
            if (bus.DMemReq && !prev_req) begin
                nreq++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req addr=%h", bus.DMemAddr);
                end else begin
                    cur    = q.pop_front();
                    active = 1;
                    chk("req_we", {31'b0, bus.DMemWe}, {31'b0, cur.we});
                end
            end
            if (bus.DMemReq && active) begin
                chk("req_addr", bus.DMemAddr, cur.addr);
                chk("req_be", {28'b0, bus.DMemBe}, {28'b0, cur.be});
                chk("req_wdata", bus.DMemWData, cur.wdata);
                chk("req_stall", {31'b0, StallM}, 32'd1);
                if (bus.DMemAck) done_nxt = 1;
            end
            prev_req = bus.DMemReq;
        end
    end

    task automatic access(input bit rd, input bit wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rr,
                          input int ack_after, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd);
        exp_t e;
        int   busy;
        int   waited;
        bit   done;
        e.we   = wr;
        e.addr = {a[31:2], 2'b00};
        e.be   = ebe;
        e.wdata = ewd;
        if (!wr) last_rd = erd;
        e.rdata  = last_rd;
        e.stalls = ack_after + 1;
        q.push_back(e);
        exp_nreq++;
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        ALUResultM = a;
        WriteDataM = wd;
        busy = 0;
        waited = 0;
        done = 0;
        while (!done && waited < 12) begin
            @(posedge CLK); #1;
            waited++;
            if (bus.DMemReq) begin
                busy++;
                if (busy == ack_after) begin
                    bus.DMemAck   = 1'b1;
                    bus.DMemRData = rr;
                    done = 1;
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL req_timeout addr=%h waited=%0d", a, waited);
        end
        @(posedge CLK); #1;
        bus.DMemAck   = 1'b0;
        bus.DMemRData = '0;
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N         = 1'b0;
        MemReadM      = 1'b1;
        MemWriteM     = 1'b0;
        Funct3M       = F3_LW;
        ALUResultM    = 32'h100;
        WriteDataM    = '0;
        bus.DMemAck   = 1'b0;
        bus.DMemRData = '0;

        @(negedge CLK);
        chk("rst_stall", {31'b0, StallM}, 32'd0);
        chk("rst_req", {31'b0, bus.DMemReq}, 32'd0);
        chk("rst_we", {31'b0, bus.DMemWe}, 32'd0);
        chk("rst_addr", bus.DMemAddr, 32'd0);
        chk("rst_be", {28'b0, bus.DMemBe}, 32'd0);
        chk("rst_wdata", bus.DMemWData, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        MemReadM = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;

        // non-memory instructions and stray ack in IDLE
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("nomem_stall", {31'b0, StallM}, 32'd0);
            chk("nomem_req", {31'b0, bus.DMemReq}, 32'd0);
        end
        @(posedge CLK); #1;
        bus.DMemAck   = 1'b1;
        bus.DMemRData = 32'hFFFF_FFFF;
        @(posedge CLK); #1;
        bus.DMemAck   = 1'b0;
        bus.DMemRData = '0;
        @(negedge CLK);
        chk("idle_ack_req", {31'b0, bus.DMemReq}, 32'd0);
        chk("idle_ack_rdata", ReadDataM, 32'd0);
        @(posedge CLK); #1;

        access(1, 0, F3_LW,  32'h100, 0, 32'hDEADBEEF, 1,
               4'b1111, 32'h0, 32'hDEADBEEF);
        access(1, 0, F3_LB,  32'h103, 0, 32'h80FFFF7F, 1,
               4'b1000, 32'h0, 32'hFFFFFF80);
        access(1, 0, F3_LBU, 32'h103, 0, 32'h80FFFF7F, 1,
               4'b1000, 32'h0, 32'h00000080);
        access(0, 1, F3_SH,  32'h202, 32'h1234ABCD, 0, 3,
               4'b1100, 32'hABCDABCD, 0);
        access(1, 0, F3_LH,  32'h102, 0, 32'h80010000, 2,
               4'b1100, 32'h0, 32'hFFFF8001);
        access(1, 0, F3_LHU, 32'h102, 0, 32'h80010000, 1,
               4'b1100, 32'h0, 32'h00008001);
        access(0, 1, F3_SB,  32'h301, 32'h000000A5, 0, 1,
               4'b0010, 32'hA5A5A5A5, 0);
        access(0, 1, F3_SW,  32'h400, 32'hCAFEF00D, 0, 1,
               4'b1111, 32'hCAFEF00D, 0);
        access(1, 1, F3_SB,  32'h402, 32'h0000007E, 32'h55555555, 1,
               4'b0100, 32'h7E7E7E7E, 0);
        access(1, 0, 3'b011, 32'h500, 0, 32'h11223344, 1,
               4'b1111, 32'h0, 32'h11223344);
        access(1, 0, F3_LB,  32'h100, 0, 32'h0000007F, 1,
               4'b0001, 32'h0, 32'h0000007F);
        // back-to-back word loads
        access(1, 0, F3_LW,  32'h600, 0, 32'hAAAA5555, 1,
               4'b1111, 32'h0, 32'hAAAA5555);
        access(1, 0, F3_LW,  32'h604, 0, 32'h0F0F0F0F, 2,
               4'b1111, 32'h0, 32'h0F0F0F0F);

`ifdef LSU_MISALIGN_TRAP_EN
        MemReadM   = 1'b1;
        Funct3M    = F3_LW;
        ALUResultM = 32'h101;
        @(negedge CLK);
        chk("mis_lw_flag", {31'b0, MisalignM}, 32'd1);
        chk("mis_lw_req", {31'b0, bus.DMemReq}, 32'd0);
        chk("mis_lw_stall", {31'b0, StallM}, 32'd0);
        @(negedge CLK);
        chk("mis_lw_req2", {31'b0, bus.DMemReq}, 32'd0);
        Funct3M = F3_LH;
        @(negedge CLK);
        chk("mis_lh_flag", {31'b0, MisalignM}, 32'd1);
        chk("mis_lh_stall", {31'b0, StallM}, 32'd0);
        MemReadM = 1'b0;
        @(posedge CLK); #1;
`else
        access(1, 0, F3_LH,  32'h101, 0, 32'h0000F00F, 1,
               4'b0011, 32'h0, 32'hFFFFF00F);
        access(1, 0, F3_LW,  32'h103, 0, 32'h12345678, 1,
               4'b1111, 32'h0, 32'h12345678);
`endif

        // reset while BUSY abandons the access
        begin
            exp_t e;
            e.we = 1'b0;
            e.addr = 32'h700;
            e.be = 4'b1111;
            e.wdata = 32'h0;
            e.rdata = 32'h0;
            e.stalls = 0;
            q.push_back(e);
            exp_nreq++;
        end
        MemReadM   = 1'b1;
        Funct3M    = F3_LW;
        ALUResultM = 32'h700;
        WriteDataM = '0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        @(negedge CLK);
        chk("rstbusy_req", {31'b0, bus.DMemReq}, 32'd0);
        chk("rstbusy_stall", {31'b0, StallM}, 32'd0);
        chk("rstbusy_rdata", ReadDataM, 32'd0);
        MemReadM = 1'b0;
        q.delete();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        bus.DMemAck   = 1'b1;
        bus.DMemRData = 32'hFFFF_FFFF;
        @(posedge CLK); #1;
        bus.DMemAck   = 1'b0;
        bus.DMemRData = '0;
        @(negedge CLK);
        chk("late_ack_req", {31'b0, bus.DMemReq}, 32'd0);
        chk("late_ack_stall", {31'b0, StallM}, 32'd0);
        chk("late_ack_rdata", ReadDataM, 32'd0);
        @(negedge CLK);
        chk("late_ack_req2", {31'b0, bus.DMemReq}, 32'd0);

        chk("req_count", nreq, exp_nreq);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have port CLK, input, 1: single clock; all state updates on posedge.
REQ-002 SHALL have port RST_N, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port MemReadM, input, 1: load in memory stage (from E-to-M register).
REQ-004 SHALL have port MemWriteM, input, 1: store in memory stage.
REQ-005 SHALL have port Funct3M, input, 3: access size/sign (RV32I funct3).
REQ-006 SHALL have port ALUResultM, input, 32: effective byte address.
REQ-007 SHALL have port WriteDataM, input, 32: store data, right-aligned.
REQ-008 SHALL have port DMemReq, output, 1: bus request, held until acknowledged.
REQ-009 SHALL have port DMemWe, output, 1: 1 = write.
REQ-010 SHALL have port DMemAddr, output, 32: word-aligned address ({ALUResultM[31:2],2'b00}).
REQ-011 SHALL have port DMemBe, output, 4: byte enables.
REQ-012 SHALL have port DMemWData, output, 32: lane-replicated store data.
REQ-013 SHALL have port DMemRData, input, 32: read word, valid with DMemAck.
REQ-014 SHALL have port DMemAck, input, 1: one-cycle completion pulse.
REQ-015 SHALL have port ReadDataM, output, 32: extended load result, to M-to-W register.
REQ-016 SHALL have port StallM, output, 1: freezes PC, F/D, D/E, E/M registers.

Function
REQ-017 SHALL implement FSM IDLE, BUSY, DONE.
REQ-018 IDLE: if (MemReadM|MemWriteM) and access permitted, StallM=1 combinationally same cycle; next state BUSY.
REQ-019 BUSY: DMemReq=1, DMemWe/DMemAddr/DMemBe/DMemWData registered at IDLE->BUSY and held stable; StallM=1; on DMemAck go DONE.
REQ-020 DONE: StallM=0, DMemReq=0, ReadDataM holds captured result; next state IDLE unconditionally (prevents re-issuing the same instruction).
REQ-021 Minimum stall: 2 cycles (ack in first BUSY cycle); each extra BUSY cycle adds one.
REQ-022 Non-memory instruction in IDLE: StallM=0, DMemReq=0, ReadDataM unchanged.
REQ-023 MemReadM and MemWriteM both 1 SHALL be treated as store.
REQ-024 DMemAck in IDLE or DONE SHALL be ignored.
REQ-025 Store BE: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
REQ-026 Store data: SB {4{b}}, SH {2{h}}, SW word.
REQ-027 Load: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass; captured on DMemAck into a 32-bit register.
REQ-028 Loads SHALL drive DMemBe per size as for stores (informational).
REQ-029 Undefined Funct3M SHALL behave as word access.

Reset
REQ-030 RST_N low SHALL asynchronously force state IDLE, DMemReq=0, DMemWe=0, DMemAddr=0, DMemBe=0, DMemWData=0, ReadDataM=0.
REQ-031 StallM SHALL be 0 while RST_N low.
REQ-032 Reset during BUSY SHALL abandon the access; a later DMemAck SHALL be ignored.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN defined: adds output MisalignM (1 bit); halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL assert MisalignM combinationally, issue no bus request, and not stall.
REQ-034 Macro undefined: no MisalignM port; misaligned addresses SHALL use truncated lane selection per REQ-025/027.

Structure
REQ-035 Shared package otter_pkg SHALL hold funct3 constants (LB..LHU, SB..SW) and the lsu_state_t enum.
REQ-036 Sub-module lsu_load_align SHALL be the combinational lane-select/extend unit.

Verification
REQ-037 LW addr 0x100, ack in first BUSY cycle, RData 0xDEADBEEF -> StallM high 2 cycles, ReadDataM=0xDEADBEEF in DONE.
REQ-038 LB addr 0x103, RData 0x80FF_FF7F -> ReadDataM=0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 SH addr 0x202, data 0x1234ABCD, ack after 3 BUSY cycles -> DMemBe=1100, DMemWData=0xABCDABCD, DMemAddr=0x200, stall 4 cycles.
REQ-040 RST_N low in BUSY then ack -> DMemReq=0 immediately, state IDLE, ack ignored, StallM=0.
REQ-041 Two back-to-back LWs -> two separate BUSY episodes, one DONE each, no duplicate request.
REQ-042 With LSU_MISALIGN_TRAP_EN: LW addr 0x101 -> MisalignM=1, DMemReq=0, StallM=0.
